alu8bit_unsigned: RTL and testbench

ALU8BIT_UNSIGNED -- requirements
Module: alu8bit_unsigned

---
 rtl/alu8bit_unsigned.sv | 85 ++++++++
 tb/tb_alu8bit_unsigned.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu8bit_unsigned.sv
// Single-cycle 8-bit unsigned ALU with registered 16-bit result and SUB borrow flag.
// Optional divider for op 1010 is built only when macro ALU_DIV_EN is defined.
module alu8bit_unsigned (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  u_a,
  input  logic [7:0]  u_b,
  input  logic [3:0]  op,
  output logic [15:0] u_result,
  output logic        borrow
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_NOT = 4'b0011,
    OP_EQ  = 4'b0100,
    OP_GT  = 4'b0101,
    OP_LT  = 4'b0110,
    OP_ADD = 4'b1000,
    OP_SUB = 4'b1001,
    OP_DIV = 4'b1010,
    OP_MUL = 4'b1011
  } op_e;

  logic [15:0] u_result_d, u_result_q;
  logic        borrow_d, borrow_q;

  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] product;

  assign sum9    = {1'b0, u_a} + {1'b0, u_b};
  // Bit 8 of the 9-bit difference is set exactly when u_a < u_b.
  assign diff9   = {1'b0, u_a} - {1'b0, u_b};
  assign product = {8'h00, u_a} * {8'h00, u_b};

`ifdef ALU_DIV_EN
  logic [7:0] quotient;
  assign quotient = u_a / u_b;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    u_result_d = 16'h0000;
    borrow_d   = 1'b0;
    case (op)
      OP_AND: u_result_d = {8'h00, u_a & u_b};
      OP_OR:  u_result_d = {8'h00, u_a | u_b};
      OP_XOR: u_result_d = {8'h00, u_a ^ u_b};
      OP_NOT: u_result_d = {8'h00, ~u_a};
      OP_EQ:  u_result_d = (u_a == u_b) ? 16'hFFFF : 16'h0000;
      OP_GT:  u_result_d = (u_a >  u_b) ? 16'hFFFF : 16'h0000;
      OP_LT:  u_result_d = (u_a <  u_b) ? 16'hFFFF : 16'h0000;
      OP_ADD: u_result_d = {7'h00, sum9};
      OP_SUB: begin
        u_result_d = {8'h00, diff9[7:0]};
        borrow_d   = diff9[8];
      end
`ifdef ALU_DIV_EN
      OP_DIV: u_result_d = (u_b == 8'h00) ? 16'hFFFF : {8'h00, quotient};
`else
      OP_DIV: u_result_d = 16'h0000;
`endif
      OP_MUL: u_result_d = product;
      default: u_result_d = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      u_result_q <= 16'h0000;
      borrow_q   <= 1'b0;
    end else begin
      u_result_q <= u_result_d;
      borrow_q   <= borrow_d;
    end
  end

  assign u_result = u_result_q;
  assign borrow   = borrow_q;

endmodule

// File: tb/tb_alu8bit_unsigned.sv
// Self-checking bench for alu8bit_unsigned: directed vector table, reset corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_alu8bit_unsigned;

  logic        clk;
  logic        nreset;
  logic [7:0]  u_a;
  logic [7:0]  u_b;
  logic [3:0]  op;
  logic [15:0] u_result;
  logic        borrow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu8bit_unsigned dut (
    .clk      (clk),
    .nreset   (nreset),
    .u_a      (u_a),
    .u_b      (u_b),
    .op       (op),
    .u_result (u_result),
    .borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        bw;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
  endtask

  // Reference model straight from the operation table, using integer arithmetic.
  task automatic model(input logic [3:0] m_op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output logic bw);
    int ia, ib;
    ia  = int'(a);
    ib  = int'(b);
    res = 16'h0000;
    bw  = 1'b0;
    case (m_op)
      4'd0:  res = 16'(ia & ib);
      4'd1:  res = 16'(ia | ib);
      4'd2:  res = 16'(ia ^ ib);
      4'd3:  res = 16'(255 - ia);
      4'd4:  res = (ia == ib) ? 16'hFFFF : 16'h0000;
      4'd5:  res = (ia >  ib) ? 16'hFFFF : 16'h0000;
      4'd6:  res = (ia <  ib) ? 16'hFFFF : 16'h0000;
      4'd8:  res = 16'(ia + ib);
      4'd9:  begin res = 16'((ia - ib + 256) % 256); bw = (ia < ib); end
`ifdef ALU_DIV_EN
      4'd10: res = (ib == 0) ? 16'hFFFF : 16'(ia / ib);
`endif
      4'd11: res = 16'(ia * ib);
      default: res = 16'h0000;
    endcase
  endtask

  task automatic apply(input logic [3:0] t_op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op  = t_op;
    u_a = a;
    u_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_res;
    logic        exp_bw;

    vecs.push_back('{4'b0000, 8'h05, 8'h02, 16'h0000, 1'b0});
    vecs.push_back('{4'b0010, 8'h27, 8'h83, 16'h00A4, 1'b0});
    vecs.push_back('{4'b0011, 8'h37, 8'h00, 16'h00C8, 1'b0});
    vecs.push_back('{4'b0100, 8'h83, 8'h83, 16'hFFFF, 1'b0});
    vecs.push_back('{4'b0101, 8'hC1, 8'h83, 16'hFFFF, 1'b0});
    vecs.push_back('{4'b0110, 8'hC7, 8'h53, 16'h0000, 1'b0});
    vecs.push_back('{4'b1000, 8'h53, 8'h73, 16'h00C6, 1'b0});
    vecs.push_back('{4'b1000, 8'hFF, 8'hFF, 16'h01FE, 1'b0});
    vecs.push_back('{4'b1001, 8'h6E, 8'h27, 16'h0047, 1'b0});
    vecs.push_back('{4'b1001, 8'h02, 8'h05, 16'h00FD, 1'b1});
    vecs.push_back('{4'b1011, 8'hA4, 8'h03, 16'h01EC, 1'b0});
    vecs.push_back('{4'b1011, 8'hFF, 8'hFF, 16'hFE01, 1'b0});
    vecs.push_back('{4'b0001, 8'hA0, 8'h05, 16'h00A5, 1'b0});
    vecs.push_back('{4'b0111, 8'hFF, 8'hFF, 16'h0000, 1'b0});
    vecs.push_back('{4'b1111, 8'h12, 8'h34, 16'h0000, 1'b0});
`ifdef ALU_DIV_EN
    vecs.push_back('{4'b1010, 8'h8A, 8'h15, 16'h0006, 1'b0});
    vecs.push_back('{4'b1010, 8'h8A, 8'h00, 16'hFFFF, 1'b0});
`else
    vecs.push_back('{4'b1010, 8'h8A, 8'h15, 16'h0000, 1'b0});
    vecs.push_back('{4'b1010, 8'h8A, 8'h00, 16'h0000, 1'b0});
`endif

    // Reset held 50 ns with live inputs; outputs must stay zero across edges.
    nreset = 1'b0;
    op     = 4'b1000;
    u_a    = 8'hFF;
    u_b    = 8'hFF;
    #47;
    check("reset_hold_result", u_result, 16'h0000);
    check("reset_hold_borrow", {15'd0, borrow}, 16'h0000);
    #3;
    nreset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_op%b_result", i, vecs[i].op), u_result, vecs[i].res);
      check($sformatf("vec%0d_op%b_borrow", i, vecs[i].op), {15'd0, borrow}, {15'd0, vecs[i].bw});
    end

    // Async reset between edges during a borrowing SUB clears outputs at once.
    apply(4'b1001, 8'h02, 8'h05);
    check("pre_reset_borrow", {15'd0, borrow}, 16'h0001);
    #2;
    nreset = 1'b0;
    #1;
    check("async_reset_result", u_result, 16'h0000);
    check("async_reset_borrow", {15'd0, borrow}, 16'h0000);

    // Held in reset through an edge, then first edge after release loads current inputs.
    apply(4'b1000, 8'hFF, 8'hFF);
    check("in_reset_edge_result", u_result, 16'h0000);
    @(negedge clk);
    nreset = 1'b1;
    op     = 4'b0011;
    u_a    = 8'h0F;
    @(posedge clk);
    #1;
    check("post_release_result", u_result, 16'h00F0);
    check("post_release_borrow", {15'd0, borrow}, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] r_op;
      logic [7:0] ra, rb;
      r_op = 4'($urandom_range(0, 15));
      ra   = 8'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'h00;
      model(r_op, ra, rb, exp_res, exp_bw);
      apply(r_op, ra, rb);
      check($sformatf("rand%0d_op%b_%02h_%02h_result", i, r_op, ra, rb), u_result, exp_res);
      check($sformatf("rand%0d_op%b_%02h_%02h_borrow", i, r_op, ra, rb), {15'd0, borrow}, {15'd0, exp_bw});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
